// File: rtl/decoder_pkg.sv
// Shared types for the registered one-hot decoder: FSM state encoding and default code width.
// Pure declarations; no timing or flow-control behaviour of its own.
package decoder_pkg;

  localparam int IN_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    SWEEP = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_decoder_reg_if.sv
// Handshake bundle between a code producer and the registered one-hot decoder.
// slave = decoder side, master = producer/consumer side driving inputs and ready.
interface onehot_decoder_reg_if
  import decoder_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
);

  localparam int OUT_W = 2 ** IN_W;

  logic             enable;
  logic [IN_W-1:0]  binary_in;
  logic             in_valid;
  logic             in_ready;
  logic             sweep_start;
  logic             sweep_busy;
  logic [OUT_W-1:0] decoder_out;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  enable, binary_in, in_valid, sweep_start, out_ready,
    output in_ready, sweep_busy, decoder_out, out_valid
  );

  modport master (
    output enable, binary_in, in_valid, sweep_start, out_ready,
    input  in_ready, sweep_busy, decoder_out, out_valid
  );

endinterface

// File: rtl/onehot_decoder_comb.sv
// Combinational binary-to-one-hot decode with an enable gate (all-zero when disabled).
// Zero latency; no flow control.
module onehot_decoder_comb #(
  parameter int IN_W = 4
) (
  input  logic [IN_W-1:0]      i_code,
  input  logic                 i_en,
  output logic [2**IN_W-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_code] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_decoder_reg.sv
// Registered one-hot decoder with a single-slot output and an ordered 0..OUT_W-1 sweep mode.
// Latency 1; in_ready tracks a free or draining slot, sweep pauses on enable low or out_ready low.
module onehot_decoder_reg
  import decoder_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_decoder_reg_if.slave  bus
);

  localparam int OUT_W = 2 ** IN_W;
  localparam logic [IN_W-1:0] LAST_IDX = '1;

  state_t           r_state;
  logic [IN_W-1:0]  r_idx;
  logic [OUT_W-1:0] r_out;
  logic             r_vld;

  logic             w_in_ready;
  logic             w_in_acc;
  logic             w_sweep_go;
  logic             w_sweep_hs;
  logic [IN_W-1:0]  w_idx_nxt;
  logic [IN_W-1:0]  w_code;
  logic             w_code_en;
  logic [OUT_W-1:0] w_onehot;

  always_comb begin
    w_in_ready = rst_n && (((r_state == IDLE) && !bus.sweep_start) ||
                           ((r_state == FULL) && bus.out_ready));
    w_in_acc   = bus.in_valid && w_in_ready;
    w_sweep_go = rst_n && (r_state == IDLE) && bus.sweep_start;
    // r_vld is always set while sweeping, so the visible handshake reduces to enable & out_ready
    w_sweep_hs = (r_state == SWEEP) && bus.enable && bus.out_ready;
    w_idx_nxt  = r_idx + IN_W'(1);
  end

  // One decoder serves both paths: sweep feeds the upcoming index, otherwise the input code
  always_comb begin
    w_code    = bus.binary_in;
    w_code_en = bus.enable;
    if (r_state == SWEEP) begin
      w_code    = w_idx_nxt;
      w_code_en = 1'b1;
    end else if (w_sweep_go) begin
      w_code    = '0;
      w_code_en = 1'b1;
    end
  end

  onehot_decoder_comb #(
    .IN_W (IN_W)
  ) u_dec (
    .i_code   (w_code),
    .i_en     (w_code_en),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_out   <= '0;
      r_vld   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sweep_go) begin
            r_state <= SWEEP;
            r_idx   <= '0;
            r_out   <= w_onehot;
            r_vld   <= 1'b1;
          end else if (w_in_acc) begin
            r_state <= FULL;
            r_out   <= w_onehot;
            r_vld   <= 1'b1;
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            if (w_in_acc) begin
              r_out <= w_onehot;
            end else begin
              r_state <= IDLE;
              r_out   <= '0;
              r_vld   <= 1'b0;
            end
          end
        end
        SWEEP: begin
          if (w_sweep_hs) begin
            if (r_idx == LAST_IDX) begin
              r_state <= IDLE;
              r_idx   <= '0;
              r_out   <= '0;
              r_vld   <= 1'b0;
            end else begin
              r_idx <= w_idx_nxt;
              r_out <= w_onehot;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
          r_out   <= '0;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.decoder_out = r_out;
  assign bus.out_valid   = r_vld && ((r_state != SWEEP) || bus.enable);
  assign bus.sweep_busy  = (r_state == SWEEP);

endmodule

// File: tb/tb_onehot_decoder_reg.sv
// Scoreboard bench for onehot_decoder_reg: accepts and sweeps push expected words, a monitor pops on output handshakes.
module tb_onehot_decoder_reg;
  import decoder_pkg::*;

  typedef struct {
    logic [15:0] dat;
    bit          sweep;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  onehot_decoder_reg_if #(.IN_W(4)) bus();

  onehot_decoder_reg #(.IN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  logic [15:0] last_pop = '0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_code(input int b, input bit en);
    return en ? 16'(2 ** b) : 16'h0000;
  endfunction

  task automatic push_sweep();
    for (int i = 0; i < 16; i++) q.push_back(exp_t'{ref_code(i, 1'b1), 1'b1});
  endtask

  // Input-side monitor: every accepted code becomes an expected output
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready)
      q.push_back(exp_t'{ref_code(int'(bus.binary_in), bus.enable), 1'b0});
  end

  // Output-side monitor: compares each transfer and checks stability under backpressure
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_stall && bus.enable) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.decoder_out), 32'(prev_dat));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0h expected no transfer", bus.decoder_out);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(bus.decoder_out), 32'(e.dat));
          chk("out_busy", 32'(bus.sweep_busy), 32'(e.sweep));
          last_pop = bus.decoder_out;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready && bus.enable;
      prev_dat   = bus.decoder_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid    = 1'b0;
    bus.sweep_start = 1'b0;
    bus.out_ready   = 1'b1;
    bus.enable      = 1'b1;
    while (q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    cyc();
  endtask

  task automatic wait_pop(input logic [15:0] v);
    int n = 0;
    while (last_pop !== v && n < 60) begin
      cyc();
      n++;
    end
    if (last_pop !== v) begin
      total++;
      bad++;
      $display("FAIL wait_pop: got %0h expected %0h", last_pop, v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.enable      = 1'b1;
    bus.binary_in   = 4'd0;
    bus.in_valid    = 1'b1;
    bus.sweep_start = 1'b0;
    bus.out_ready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'(bus.decoder_out), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.sweep_busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    cyc();

    // Code 5, then slot empties the following cycle
    bus.binary_in = 4'd5;
    bus.in_valid  = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("after_xfer_valid", 32'(bus.out_valid), 32'd0);
    chk("after_xfer_data", 32'(bus.decoder_out), 32'h0);
    cyc();

    // Disabled accept delivers a zero code
    bus.binary_in = 4'd9;
    bus.enable    = 1'b0;
    bus.in_valid  = 1'b1;
    cyc();
    drain();

    // Backpressure then a back-to-back stream
    bus.out_ready = 1'b0;
    bus.binary_in = 4'd3;
    bus.in_valid  = 1'b1;
    cyc();
    bus.binary_in = 4'd1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_data", 32'(bus.decoder_out), 32'h0008);
      cyc();
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i = i * 2) begin
      bus.binary_in = 4'(i);
      @(negedge clk);
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      cyc();
    end
    drain();

    // sweep_start while an output is pending is dropped
    bus.out_ready = 1'b0;
    bus.binary_in = 4'd1;
    bus.in_valid  = 1'b1;
    cyc();
    bus.in_valid    = 1'b0;
    bus.sweep_start = 1'b1;
    cyc();
    bus.sweep_start = 1'b0;
    @(negedge clk);
    chk("full_sweep_ignored", 32'(bus.sweep_busy), 32'd0);
    cyc();
    drain();

    // Sweep wins over a simultaneous input, with random backpressure and a stray sweep_start
    bus.sweep_start = 1'b1;
    bus.in_valid    = 1'b1;
    bus.binary_in   = 4'd7;
    push_sweep();
    @(negedge clk);
    chk("sweep_prio_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    bus.sweep_start = 1'b0;
    bus.in_valid    = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      bus.out_ready   = 1'($urandom_range(0, 1));
      bus.sweep_start = (n == 5);
      cyc();
      n++;
    end
    bus.sweep_start = 1'b0;
    @(negedge clk);
    chk("sweep_end_busy", 32'(bus.sweep_busy), 32'd0);
    chk("sweep_end_valid", 32'(bus.out_valid), 32'd0);
    chk("sweep_end_data", 32'(bus.decoder_out), 32'h0);
    cyc();
    drain();

    // Pause at index 6, then reset at index 10
    last_pop = '0;
    bus.sweep_start = 1'b1;
    push_sweep();
    cyc();
    bus.sweep_start = 1'b0;
    wait_pop(16'h0020);
    bus.enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("pause_valid", 32'(bus.out_valid), 32'd0);
      chk("pause_data", 32'(bus.decoder_out), 32'h0040);
      chk("pause_busy", 32'(bus.sweep_busy), 32'd1);
      cyc();
    end
    bus.enable = 1'b1;
    wait_pop(16'h0200);
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.binary_in = 4'd2;
    q.delete();
    cyc();
    @(negedge clk);
    chk("midrst_out", 32'(bus.decoder_out), 32'h0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.sweep_busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    drain();

    // Random single-code traffic
    repeat (400) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.binary_in = 4'($urandom_range(0, 15));
      bus.enable    = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    drain();

    // Random sweeps with enable/out_ready/in_valid noise
    repeat (3) begin
      bus.sweep_start = 1'b1;
      push_sweep();
      cyc();
      bus.sweep_start = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 300) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.binary_in = 4'($urandom_range(0, 15));
        bus.enable    = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        cyc();
        n++;
      end
      drain();
    end

    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_reg.md
ONEHOT_DECODER_REG -- requirements
Module: onehot_decoder_reg

Interface
REQ-001 Parameter: IN_W, 4, binary input width; OUT_W = 2**IN_W (16) is derived, not overridable.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 enable  input  1  decode enable; low forces a zero code on accept and pauses sweep.
REQ-005 binary_in  input  IN_W  binary code to decode.
REQ-006 in_valid  input  1  binary_in valid.
REQ-007 in_ready  output  1  block accepts binary_in this cycle.
REQ-008 sweep_start  input  1  single-cycle request to emit all 16 one-hot codes in order.
REQ-009 sweep_busy  output  1  sweep in progress.
REQ-010 decoder_out  output  OUT_W  registered one-hot (or all-zero) code.
REQ-011 out_valid  output  1  decoder_out valid.
REQ-012 out_ready  input  1  downstream accepts decoder_out.

Function
REQ-013 FSM states SHALL be IDLE (no pending output), FULL (output pending), SWEEP.
REQ-014 in_ready SHALL be combinational: (IDLE and not sweep_start) or (FULL and out_ready); 0 in SWEEP.
REQ-015 Input accept (in_valid and in_ready) SHALL load decoder_out = 1 << binary_in if enable, else 16'h0000, with out_valid = 1 on the next cycle (latency 1); state -> FULL.
REQ-016 In FULL, decoder_out and out_valid SHALL hold stable until out_ready; on out_ready without a new accept, out_valid -> 0, decoder_out -> 0, state -> IDLE.
REQ-017 In FULL, out_ready together with in_valid SHALL replace the output back-to-back with no bubble (one transfer per cycle).
REQ-018 sweep_start in IDLE SHALL take priority over in_valid; the next cycle enters SWEEP with index 0, decoder_out = 16'h0001, out_valid = 1, sweep_busy = 1.
REQ-019 sweep_start in FULL or SWEEP SHALL be ignored (not latched).
REQ-020 In SWEEP, the index SHALL advance by 1 only on out_valid and out_ready; decoder_out = 1 << index.
REQ-021 Handshake at index 15 SHALL end the sweep: next cycle state IDLE, out_valid = 0, decoder_out = 0, sweep_busy = 0; no wrap to index 0.
REQ-022 enable low in SWEEP SHALL deassert out_valid and freeze the index; decoder_out holds its last value; enable high resumes at the same index.
REQ-023 enable SHALL have no effect on an output already registered in FULL.
REQ-024 The 4-bit sweep index SHALL never exceed 15; no other arithmetic is present.

Reset
REQ-025 rst_n low at a clock edge SHALL force IDLE, decoder_out = 0, out_valid = 0, sweep_busy = 0, sweep index = 0, from any state, including mid-sweep or with an output pending.
REQ-026 During reset in_ready SHALL read 0; the first accept SHALL be possible on the first edge after rst_n returns high.

Structure
REQ-027 Package decoder_pkg SHALL hold the state enum (IDLE, FULL, SWEEP) and the IN_W default constant.
REQ-028 Combinational decode SHALL be a sub-module onehot_decoder_comb (IN_W in, OUT_W out, enable gate), shared by the input path and the sweep path.
REQ-029 The output register and FSM SHALL live in onehot_decoder_reg; there SHALL be no combinational path from binary_in to decoder_out.

Verification
REQ-030 Accept binary_in = 4'd5 with enable = 1 and out_ready = 1 -> one cycle later decoder_out = 16'h0020, out_valid = 1; the following cycle decoder_out = 0, out_valid = 0.
REQ-031 Accept 4'd9 with enable = 0 -> decoder_out = 16'h0000 with out_valid = 1 (zero code delivered, not dropped).
REQ-032 out_ready = 0 for 5 cycles after accepting 4'd3 -> decoder_out stays 16'h0008 and in_ready = 0 throughout; then a stream of 1, 2, 4 with out_ready = 1 -> 16'h0002, 16'h0004, 16'h0010 on consecutive cycles.
REQ-033 sweep_start and in_valid (binary_in = 4'd7) in the same IDLE cycle -> in_ready = 0, the sweep runs, the 16 outputs are 16'h0001 through 16'h8000 in order, and sweep_busy falls after the 16h'8000 handshake.
REQ-034 Mid-sweep at index 6: drop enable for 3 cycles -> out_valid = 0, the index is held, and the sweep resumes with 16'h0040; at index 10, assert rst_n = 0 -> all outputs are 0 and the state is IDLE next cycle.
